// File: rtl/sterownik_licznika.sv
// Sweep controller for a loadable up/down counter: preloads lo, sweeps lo->hi->lo for N round trips, parks it when idle.
// Latency: Moore outputs, one edge from accepted start to PRELOAD; no backpressure, i_Start is simply ignored while busy.
module sterownik_licznika #(
    parameter int LENGTH = 4,
    parameter int REP_W  = 8
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Start,
    input  logic              i_Stop,
    input  logic [LENGTH-1:0] i_Low_Bound,
    input  logic [LENGTH-1:0] i_High_Bound,
    input  logic [REP_W-1:0]  i_Repeats,
    input  logic [LENGTH-1:0] i_Counter,
    output logic              o_Load_Signal,
    output logic [LENGTH-1:0] o_Load_Data,
    output logic              o_Direction,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Error,
    output logic [REP_W-1:0]  o_Sweeps
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    localparam logic [LENGTH-1:0] CNT_ONE = {{(LENGTH-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0]  REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [LENGTH-1:0] park, park_nxt;
    logic [LENGTH-1:0] lo, lo_nxt;
    logic [LENGTH-1:0] hi, hi_nxt;
    logic [REP_W-1:0]  reps, reps_nxt;
    logic [REP_W-1:0]  sweeps, sweeps_nxt;
    logic              error, error_nxt;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state  <= S_IDLE;
            park   <= '0;
            lo     <= '0;
            hi     <= '0;
            reps   <= '0;
            sweeps <= '0;
            error  <= 1'b0;
        end else begin
            state  <= state_nxt;
            park   <= park_nxt;
            lo     <= lo_nxt;
            hi     <= hi_nxt;
            reps   <= reps_nxt;
            sweeps <= sweeps_nxt;
            error  <= error_nxt;
        end
    end

    // On stop, park is the value the counter takes at this same edge, so it freezes without a glitch.
    always_comb begin
        state_nxt  = state;
        park_nxt   = park;
        lo_nxt     = lo;
        hi_nxt     = hi;
        reps_nxt   = reps;
        sweeps_nxt = sweeps;
        error_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_Start && !i_Stop) begin
                    if (i_Low_Bound < i_High_Bound) begin
                        lo_nxt     = i_Low_Bound;
                        hi_nxt     = i_High_Bound;
                        reps_nxt   = i_Repeats;
                        sweeps_nxt = '0;
                        state_nxt  = S_PRELOAD;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
            end
            S_PRELOAD: begin
                if (i_Stop) begin
                    park_nxt  = lo;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_UP;
                end
            end
            S_UP: begin
                if (i_Stop) begin
                    park_nxt  = i_Counter + CNT_ONE;
                    state_nxt = S_IDLE;
                end else if (i_Counter == hi - CNT_ONE) begin
                    state_nxt = S_DOWN;
                end
            end
            S_DOWN: begin
                if (i_Stop) begin
                    park_nxt  = i_Counter - CNT_ONE;
                    state_nxt = S_IDLE;
                end else if (i_Counter == lo + CNT_ONE) begin
                    sweeps_nxt = sweeps + REP_ONE;
                    if (reps != '0 && sweeps + REP_ONE == reps) begin
                        park_nxt  = lo;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_UP;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_Load_Signal = (state == S_IDLE) || (state == S_PRELOAD) || (state == S_DONE);
    assign o_Load_Data   = (state == S_PRELOAD) ? lo : park;
    assign o_Direction   = (state != S_DOWN);
    assign o_Busy        = (state == S_PRELOAD) || (state == S_UP) || (state == S_DOWN);
    assign o_Done        = (state == S_DONE);
    assign o_Error       = error;
    assign o_Sweeps      = sweeps;

endmodule

// File: tb/tb_sterownik_licznika.sv
// Closed-loop bench: a 4-bit loadable up/down counter is driven by the controller and fed back to it.
module tb_sterownik_licznika;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [3:0] lo_b;
    logic [3:0] hi_b;
    logic [7:0] reps_b;
    logic [3:0] ctr;
    logic       load;
    logic [3:0] ldata;
    logic       dir;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] sweeps;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    bit chk_en = 0;

    sterownik_licznika #(.LENGTH(4), .REP_W(8)) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Start      (start),
        .i_Stop       (stop),
        .i_Low_Bound  (lo_b),
        .i_High_Bound (hi_b),
        .i_Repeats    (reps_b),
        .i_Counter    (ctr),
        .o_Load_Signal(load),
        .o_Load_Data  (ldata),
        .o_Direction  (dir),
        .o_Busy       (busy),
        .o_Done       (done),
        .o_Error      (err),
        .o_Sweeps     (sweeps)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // The counter being steered.
    initial ctr = 4'd0;
    always @(posedge clk) ctr <= load ? ldata : (dir ? ctr + 4'd1 : ctr - 4'd1);

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting for condition", name);
    endtask

    // Reference model: a sweep is expanded into a list of per-cycle expected outputs.
    typedef struct {
        bit       load;
        bit       dir;
        bit [3:0] data;
        bit       busy;
        bit       done;
        bit [7:0] sweeps;
    } exp_t;

    exp_t     q[$];
    exp_t     cur;
    bit [3:0] m_cnt  = 4'd0;
    bit [3:0] m_park = 4'd0;
    bit       m_err  = 1'b0;

    function automatic exp_t mk(bit l, bit d, bit [3:0] dat, bit b, bit dn, bit [7:0] s);
        exp_t e;
        e.load = l; e.dir = d; e.data = dat; e.busy = b; e.done = dn; e.sweeps = s;
        return e;
    endfunction

    task automatic build(input bit [3:0] l, input bit [3:0] h, input bit [7:0] r);
        int n;
        int d;
        q.delete();
        n = (r == 0) ? 256 : int'(r);
        d = int'(h) - int'(l);
        q.push_back(mk(1, 1, l, 1, 0, 8'd0));
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < d; k++) q.push_back(mk(0, 1, 4'd0, 1, 0, 8'(t)));
            for (int k = 0; k < d; k++) q.push_back(mk(0, 0, 4'd0, 1, 0, 8'(t)));
        end
        if (r != 0) q.push_back(mk(1, 1, l, 0, 1, 8'(n)));
        m_park = l;
    endtask

    initial cur = mk(1, 1, 4'd0, 0, 0, 8'd0);

    always @(posedge clk) begin : model
        bit [3:0] nc;
        nc = cur.load ? cur.data : (cur.dir ? m_cnt + 4'd1 : m_cnt - 4'd1);
        m_err = 1'b0;
        if (rst) begin
            q.delete();
            m_park = 4'd0;
            cur = mk(1, 1, 4'd0, 0, 0, 8'd0);
        end else if (cur.busy && stop) begin
            q.delete();
            m_park = nc;
            cur = mk(1, 1, nc, 0, 0, cur.sweeps);
        end else if (!cur.busy && !cur.done && start && !stop) begin
            if (lo_b < hi_b) begin
                build(lo_b, hi_b, reps_b);
                cur = q.pop_front();
            end else begin
                m_err = 1'b1;
            end
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else begin
            cur = mk(1, 1, m_park, 0, 0, cur.sweeps);
        end
        m_cnt = nc;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("load", 32'(load), 32'(cur.load));
            if (cur.load) chk("data", 32'(ldata), 32'(cur.data));
            chk("dir", 32'(dir), 32'(cur.dir));
            chk("busy", 32'(busy), 32'(cur.busy));
            chk("done", 32'(done), 32'(cur.done));
            chk("error", 32'(err), 32'(m_err));
            chk("sweeps", 32'(sweeps), 32'(cur.sweeps));
            chk("counter", 32'(ctr), 32'(m_cnt));
        end
    end

    task automatic start_sweep(input bit [3:0] l, input bit [3:0] h, input bit [7:0] r);
        lo_b = l; hi_b = h; reps_b = r; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    logic [3:0] seq_exp [13];
    bit found;
    int d0;

    initial begin
        rst = 1; start = 0; stop = 0; lo_b = 0; hi_b = 0; reps_b = 0;
        repeat (3) @(negedge clk);
        chk("rst_load", 32'(load), 32'd1);
        chk("rst_data", 32'(ldata), 32'd0);
        chk("rst_dir", 32'(dir), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_ctr", 32'(ctr), 32'd0);
        chk_en = 1;
        rst = 0;
        @(negedge clk);

        // lo=3 hi=6 reps=2: two full round trips
        seq_exp = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd5, 4'd4, 4'd3, 4'd4, 4'd5, 4'd6, 4'd5, 4'd4, 4'd3};
        d0 = done_cnt;
        start_sweep(4'd3, 4'd6, 8'd2);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk($sformatf("seq[%0d]", i), 32'(ctr), 32'(seq_exp[i]));
            if (i == 6) chk("sweeps_1", 32'(sweeps), 32'd1);
            if (i == 12) chk("done_pulse", 32'(done), 32'd1);
        end
        repeat (3) @(negedge clk);
        chk("sweeps_2", 32'(sweeps), 32'd2);
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("parked_lo", 32'(ctr), 32'd3);

        // Rejected starts
        start_sweep(4'd7, 4'd7, 8'd1);
        chk("err_eq", {30'd0, err, busy}, 32'd2);
        @(negedge clk);
        chk("err_eq_clr", 32'(err), 32'd0);
        start_sweep(4'd9, 4'd2, 8'd1);
        chk("err_gt", {30'd0, err, busy}, 32'd2);
        @(negedge clk);
        chk("err_ctr_unchanged", 32'(ctr), 32'd3);

        // Endless sweep, stopped while counting up at 10
        d0 = done_cnt;
        start_sweep(4'd0, 4'd15, 8'd0);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (ctr == 4'd10 && dir && busy) found = 1;
        end
        if (!found) timeout_fail("stop_wait");
        stop = 1;
        @(negedge clk);
        stop = 0;
        repeat (2) @(negedge clk);
        chk("stop_ctr", 32'(ctr), 32'd11);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_no_done", 32'(done_cnt - d0), 32'd0);

        // Start and stop together from idle
        stop = 1;
        start_sweep(4'd2, 4'd9, 8'd1);
        stop = 0;
        chk("startstop_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("startstop_ctr", 32'(ctr), 32'd11);

        // Start while busy is ignored
        d0 = done_cnt;
        start_sweep(4'd2, 4'd5, 8'd1);
        repeat (2) @(negedge clk);
        start_sweep(4'd0, 4'd15, 8'd5);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1;
        end
        if (!found) timeout_fail("midstart_done");
        @(negedge clk);
        chk("midstart_ctr", 32'(ctr), 32'd2);
        chk("midstart_sweeps", 32'(sweeps), 32'd1);

        // Reset in DOWN at counter 5
        start_sweep(4'd1, 4'd8, 8'd0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ctr == 4'd5 && !dir && busy) found = 1;
        end
        if (!found) timeout_fail("rst_wait");
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_load", 32'(load), 32'd1);
        chk("midrst_data", 32'(ldata), 32'd0);
        chk("midrst_sweeps", 32'(sweeps), 32'd0);
        @(negedge clk);
        chk("midrst_ctr", 32'(ctr), 32'd0);

        // Randomized traffic checked cycle by cycle against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            rst   = ($urandom_range(0, 399) == 0);
            reps_b = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                lo_b = 4'($urandom);
                hi_b = 4'($urandom);
            end else begin
                lo_b = 4'($urandom_range(0, 14));
                hi_b = 4'($urandom_range(int'(lo_b) + 1, 15));
            end
        end
        @(negedge clk);
        start = 0; stop = 0; rst = 0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sterownik_licznika.md
Name: sterownik_licznika

Overview:
- Sweep controller sitting directly upstream of the team's bidirectional loadable up/down counter.
- Drives the counter's load strobe, load data and direction inputs.
- Reads the counter value back, to make it sweep low→high→low between programmable bounds for a programmed number of round trips.
- Holds the counter frozen via continuous load while idle.

Parameters:
LENGTH, 4, counter width in bits (must match the driven counter).
REP_W, 8, width of repeat count and sweep counter.

Ports:
i_Clk  input  1  clock, rising edge.
i_Reset  input  1  synchronous, active-high reset.
i_Start  input  1  start request, sampled every edge; ignored unless idle.
i_Stop  input  1  abort request; priority over i_Start.
i_Low_Bound  input  LENGTH  lower sweep bound, latched on accepted start.
i_High_Bound  input  LENGTH  upper sweep bound, latched on accepted start.
i_Repeats  input  REP_W  round trips to perform, latched on start; 0 = run until stopped.
i_Counter  input  LENGTH  current counter output (feedback).
o_Load_Signal  output  1  counter load strobe.
o_Load_Data  output  LENGTH  counter load value.
o_Direction  output  1  1 = count up, 0 = count down.
o_Busy  output  1  high in PRELOAD/UP/DOWN.
o_Done  output  1  one-cycle pulse on normal completion.
o_Error  output  1  one-cycle pulse on rejected start.
o_Sweeps  output  REP_W  completed round trips since last start.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; park, lo, hi, reps and o_Sweeps = 0.
  - o_Done = o_Error = 0.
  - Resulting outputs: Load=1, Data=0, Dir=1, Busy=0, so the counter is forced to 0 on the next edge.
  - Reset mid-sweep behaves identically; no Done pulse.
- Output decode (Moore, no combinational input→output path):
  - IDLE/DONE: Load=1, Data=park, Dir=1.
  - PRELOAD: Load=1, Data=lo, Dir=1.
  - UP: Load=0, Dir=1.
  - DOWN: Load=0, Dir=0.
- IDLE:
  - i_Start=1 and Low<High: latch lo, hi, reps; clear o_Sweeps; →PRELOAD.
  - i_Start=1 and Low>=High: o_Error=1 for one cycle; stay IDLE; latched values unchanged.
- PRELOAD: one cycle; counter takes lo at the exiting edge; →UP.
- UP: when i_Counter==hi-1 at an edge, the counter reaches hi at that edge; →DOWN.
  - hi==lo+1 gives exactly one UP cycle.
- DOWN: when i_Counter==lo+1 at an edge, the counter reaches lo at that edge and o_Sweeps increments (wraps modulo 2^REP_W).
  - If reps!=0 and o_Sweeps+1==reps: park←lo; →DONE.
  - Otherwise →UP.
- DONE: o_Done=1 for that single cycle; →IDLE. The counter stays at lo throughout.
- i_Stop in PRELOAD/UP/DOWN:
  - park ← value the counter takes at that edge: i_Counter+1 in UP, i_Counter-1 in DOWN (mod 2^LENGTH), lo in PRELOAD.
  - →IDLE; no Done pulse. The counter freezes at park from the following edge.
- i_Stop in IDLE/DONE: ignored.
- i_Start and i_Stop together: stop wins; start dropped.
- i_Start while busy: ignored; bound/repeat input changes while busy: ignored.
- Timing: start edge → PRELOAD; counter=lo one edge later. One round trip takes 2·(hi−lo) cycles in UP+DOWN.
- All arithmetic is unsigned, LENGTH-bit compare; lo+1 and hi-1 cannot overflow given lo<hi.

Test Plan:
- Reset, LENGTH=4, hold 3 cycles → Load=1, Data=0, Dir=1, Busy=0, Done=Error=0; modelled counter=0.
- Start lo=3, hi=6, reps=2, closed loop with counter model → counter sequence 3,4,5,6,5,4,3,4,5,6,5,4,3; o_Sweeps 1 then 2; o_Done one pulse; counter stays 3 afterwards.
- Start lo=7, hi=7 → o_Error one pulse, stays IDLE, counter unchanged; then lo=9, hi=2 → same.
- Start lo=0, hi=15, reps=0; assert i_Stop while counter=10 counting up → counter freezes at 11, no o_Done, Busy=0.
- Start and Stop in the same cycle from IDLE → no state change; start mid-sweep → ignored, sweep unaffected.
- Assert i_Reset during DOWN at counter=5 → next cycle Load=1, Data=0, o_Sweeps=0; counter goes to 0.
